soc_tcdm_xbar_rr: RTL

Parametrised TCDM crossbar connecting NR_MASTERS TCDM initiators to NR_SLAVES TCDM targets selected by an address-rule table, with per-slave round-robin arbitration and per-slave in-order response routing. It replaces the fixed-port contiguous crossbar inside the SoC interconnect: master count, slave count, rule count and outstanding depth are all parameters. It supports variable-latency slaves, which the fixed-latency predecessor cannot.

---
 rtl/soc_tcdm_xbar_rr_if.sv | 57 +++++
 rtl/soc_tcdm_xbar_rr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/soc_tcdm_xbar_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_tcdm_xbar_rr_if                                             |
// | Purpose  : TCDM crossbar bus bundle. It carries every initiator-side and   |
// |            target-side handshake signal of soc_tcdm_xbar_rr.               |
// | Modports : slave  - crossbar view (takes master requests, drives slaves)   |
// |            master - environment view (drives master requests and slave     |
// |                     grants/responses)                                      |
// | Signals  : m_req_i/m_wen_i/m_add_i/m_wdata_i/m_be_i      initiator request |
// |            m_gnt_o/m_r_valid_o/m_r_opc_o/m_r_rdata_o     initiator response|
// |            s_req_o/s_wen_o/s_add_o/s_wdata_o/s_be_o      target request    |
// |            s_gnt_i/s_r_valid_i/s_r_opc_i/s_r_rdata_i     target response   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface soc_tcdm_xbar_rr_if #(
  parameter int NR_MASTERS = 9,
  parameter int NR_SLAVES  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NR_MASTERS-1:0]                 m_req_i;
  logic [NR_MASTERS-1:0]                 m_wen_i;
  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i;
  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NR_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i;
  logic [NR_MASTERS-1:0]                 m_gnt_o;
  logic [NR_MASTERS-1:0]                 m_r_valid_o;
  logic [NR_MASTERS-1:0]                 m_r_opc_o;
  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] m_r_rdata_o;

  logic [NR_SLAVES-1:0]                  s_req_o;
  logic [NR_SLAVES-1:0]                  s_wen_o;
  logic [NR_SLAVES-1:0][ADDR_WIDTH-1:0]  s_add_o;
  logic [NR_SLAVES-1:0][DATA_WIDTH-1:0]  s_wdata_o;
  logic [NR_SLAVES-1:0][BE_WIDTH-1:0]    s_be_o;
  logic [NR_SLAVES-1:0]                  s_gnt_i;
  logic [NR_SLAVES-1:0]                  s_r_valid_i;
  logic [NR_SLAVES-1:0]                  s_r_opc_i;
  logic [NR_SLAVES-1:0][DATA_WIDTH-1:0]  s_r_rdata_i;

  modport slave (
    input  m_req_i, m_wen_i, m_add_i, m_wdata_i, m_be_i,
    output m_gnt_o, m_r_valid_o, m_r_opc_o, m_r_rdata_o,
    output s_req_o, s_wen_o, s_add_o, s_wdata_o, s_be_o,
    input  s_gnt_i, s_r_valid_i, s_r_opc_i, s_r_rdata_i
  );

  modport master (
    output m_req_i, m_wen_i, m_add_i, m_wdata_i, m_be_i,
    input  m_gnt_o, m_r_valid_o, m_r_opc_o, m_r_rdata_o,
    input  s_req_o, s_wen_o, s_add_o, s_wdata_o, s_be_o,
    output s_gnt_i, s_r_valid_i, s_r_opc_i, s_r_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/soc_tcdm_xbar_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_tcdm_xbar_rr                                                |
// | Purpose  : NR_MASTERS x NR_SLAVES TCDM crossbar. Address-rule decode,      |
// |            per-slave round-robin arbitration, per-slave master-ID FIFO for |
// |            in-order response routing, per-master ordering guard so that a  |
// |            master only switches target once all its responses are back.    |
// | Ports    : clk_i, rst_i (async, active-high)                               |
// |            rule_idx_i/rule_start_i/rule_end_i  address map [start, end)    |
// |            bus (soc_tcdm_xbar_rr_if.slave)     master and slave handshakes |
// | Options  : SOC_TCDM_XBAR_DECERR_EN - internal error slave (target index    |
// |            NR_SLAVES) answers unmapped addresses with opc=1, 0xBADACCE5.   |
// |            Undefined: unmapped addresses go to slave DEFAULT_IDX.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module soc_tcdm_xbar_rr #(
  parameter int  NR_MASTERS      = 9,
  parameter int  NR_SLAVES       = 3,
  parameter int  NR_RULES        = 3,
  parameter int  ADDR_WIDTH      = 32,
  parameter int  DATA_WIDTH      = 32,
  parameter int  MAX_OUTSTANDING = 2,
  parameter int  DEFAULT_IDX     = 0,
  localparam int SLV_W           = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1
) (
  input  wire                                clk_i,
  input  wire                                rst_i,
  input  wire [NR_RULES-1:0][SLV_W-1:0]      rule_idx_i,
  input  wire [NR_RULES-1:0][ADDR_WIDTH-1:0] rule_start_i,
  input  wire [NR_RULES-1:0][ADDR_WIDTH-1:0] rule_end_i,
  soc_tcdm_xbar_rr_if.slave                  bus
);
`ifdef SOC_TCDM_XBAR_DECERR_EN
  localparam int NR_TGT = NR_SLAVES + 1;
`else
  localparam int NR_TGT = NR_SLAVES;
`endif
  localparam int TGT_W = (NR_TGT > 1) ? $clog2(NR_TGT) : 1;
  localparam int MST_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // State
  logic [NR_MASTERS-1:0][CNT_W-1:0] r_mst_cnt;
  logic [NR_MASTERS-1:0][TGT_W-1:0] r_mst_last;
  logic [NR_TGT-1:0][MST_W-1:0]     r_rr_ptr;
  logic [MST_W-1:0]                 r_fifo [NR_TGT][MAX_OUTSTANDING];
  logic [NR_TGT-1:0][PTR_W-1:0]     r_wr_ptr;
  logic [NR_TGT-1:0][PTR_W-1:0]     r_rd_ptr;
  logic [NR_TGT-1:0][CNT_W-1:0]     r_fifo_cnt;

  // Combinational
  logic [NR_MASTERS-1:0][TGT_W-1:0] w_tgt;
  logic [NR_MASTERS-1:0]            w_req_ok;
  logic [NR_TGT-1:0]                w_any, w_tgt_req, w_tgt_gnt, w_hs, w_rsp, w_tgt_opc;
  logic [NR_TGT-1:0][MST_W-1:0]     w_sel, w_head;
  logic [NR_TGT-1:0][DATA_WIDTH-1:0] w_tgt_rdata;
  logic [NR_MASTERS-1:0]            w_m_gnt, w_m_rvalid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode plus ordering guard. Rules are scanned high to low so the
  // lowest-numbered match is the last write and wins.
  always_comb begin
    for (int m = 0; m < NR_MASTERS; m++) begin
`ifdef SOC_TCDM_XBAR_DECERR_EN
      w_tgt[m] = TGT_W'(NR_SLAVES);
`else
      w_tgt[m] = TGT_W'(DEFAULT_IDX);
`endif
      for (int r = NR_RULES - 1; r >= 0; r--) begin
        if ((bus.m_add_i[m] >= rule_start_i[r]) && (bus.m_add_i[m] < rule_end_i[r]))
          w_tgt[m] = TGT_W'(rule_idx_i[r]);
      end
      // A target switch must wait until every earlier response is delivered.
      w_req_ok[m] = bus.m_req_i[m] &&
                    ((r_mst_cnt[m] == '0) || (r_mst_last[m] == w_tgt[m]));
    end
  end

  // Per-target round-robin arbitration and target-side drive.
  always_comb begin : p_arb
    int idx;
    idx            = 0;
    bus.s_req_o    = '0;
    bus.s_wen_o    = '0;
    bus.s_add_o    = '0;
    bus.s_wdata_o  = '0;
    bus.s_be_o     = '0;
    w_tgt_gnt      = '0;
    w_tgt_opc      = '0;
    w_tgt_rdata    = '0;
    w_rsp          = '0;
    for (int t = 0; t < NR_TGT; t++) begin
      w_any[t] = 1'b0;
      w_sel[t] = '0;
      for (int i = 0; i < NR_MASTERS; i++) begin
        idx = int'(r_rr_ptr[t]) + i;
        if (idx >= NR_MASTERS) idx = idx - NR_MASTERS;
        if (!w_any[t] && w_req_ok[idx] && (w_tgt[idx] == TGT_W'(t))) begin
          w_any[t] = 1'b1;
          w_sel[t] = MST_W'(idx);
        end
      end
      // Full FIFO blocks requests even when a pop happens this cycle, so
      // grant never depends combinationally on r_valid.
      w_tgt_req[t] = w_any[t] && (r_fifo_cnt[t] != CNT_W'(MAX_OUTSTANDING));
      w_head[t]    = r_fifo[t][r_rd_ptr[t]];
    end
    for (int t = 0; t < NR_SLAVES; t++) begin
      bus.s_req_o[t]   = w_tgt_req[t];
      bus.s_wen_o[t]   = bus.m_wen_i[w_sel[t]];
      bus.s_add_o[t]   = bus.m_add_i[w_sel[t]];
      bus.s_wdata_o[t] = bus.m_wdata_i[w_sel[t]];
      bus.s_be_o[t]    = bus.m_be_i[w_sel[t]];
      w_tgt_gnt[t]     = bus.s_gnt_i[t];
      // Responses arriving with nothing outstanding are dropped.
      w_rsp[t]         = bus.s_r_valid_i[t] && (r_fifo_cnt[t] != '0);
      w_tgt_opc[t]     = bus.s_r_opc_i[t];
      w_tgt_rdata[t]   = bus.s_r_rdata_i[t];
    end
`ifdef SOC_TCDM_XBAR_DECERR_EN
    // Error slave grants at once and answers the cycle after each grant;
    // its FIFO never holds more than one entry, so "non-empty" is "due".
    w_tgt_gnt[NR_SLAVES]   = 1'b1;
    w_rsp[NR_SLAVES]       = (r_fifo_cnt[NR_SLAVES] != '0);
    w_tgt_opc[NR_SLAVES]   = 1'b1;
    w_tgt_rdata[NR_SLAVES] = DATA_WIDTH'(32'hBADACCE5);
`endif
    w_hs = w_tgt_req & w_tgt_gnt;
  end

  // Master-side grant and response routing (FIFO head picks the master).
  always_comb begin
    w_m_gnt         = '0;
    w_m_rvalid      = '0;
    bus.m_r_opc_o   = '0;
    bus.m_r_rdata_o = '0;
    for (int m = 0; m < NR_MASTERS; m++) begin
      for (int t = 0; t < NR_TGT; t++) begin
        if (w_hs[t] && (w_sel[t] == MST_W'(m))) w_m_gnt[m] = 1'b1;
        if (w_rsp[t] && (w_head[t] == MST_W'(m))) begin
          w_m_rvalid[m]      = 1'b1;
          bus.m_r_opc_o[m]   = w_tgt_opc[t];
          bus.m_r_rdata_o[m] = w_tgt_rdata[t];
        end
      end
    end
  end

  assign bus.m_gnt_o     = w_m_gnt;
  assign bus.m_r_valid_o = w_m_rvalid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mst_cnt  <= '0;
      r_mst_last <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      for (int t = 0; t < NR_TGT; t++)
        for (int k = 0; k < MAX_OUTSTANDING; k++)
          r_fifo[t][k] <= '0;
    end else begin
      for (int m = 0; m < NR_MASTERS; m++) begin
        if (w_m_gnt[m] && !w_m_rvalid[m])      r_mst_cnt[m] <= r_mst_cnt[m] + 1'b1;
        else if (!w_m_gnt[m] && w_m_rvalid[m]) r_mst_cnt[m] <= r_mst_cnt[m] - 1'b1;
        if (w_m_gnt[m]) r_mst_last[m] <= w_tgt[m];
      end
      for (int t = 0; t < NR_TGT; t++) begin
        if (w_hs[t]) begin
          r_rr_ptr[t] <= (w_sel[t] == MST_W'(NR_MASTERS - 1)) ? '0 : w_sel[t] + 1'b1;
          r_fifo[t][r_wr_ptr[t]] <= w_sel[t];
          r_wr_ptr[t] <= ptr_inc(r_wr_ptr[t]);
        end
        if (w_rsp[t]) r_rd_ptr[t] <= ptr_inc(r_rd_ptr[t]);
        if (w_hs[t] && !w_rsp[t])      r_fifo_cnt[t] <= r_fifo_cnt[t] + 1'b1;
        else if (!w_hs[t] && w_rsp[t]) r_fifo_cnt[t] <= r_fifo_cnt[t] - 1'b1;
      end
    end
  end
endmodule
`default_nettype wire
